// File: rtl/pixel_state.sv
// pixel_state: free-running frame sequencer for the pixel-sensor array.
// Cycles IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> IDLE, driving one-hot
// strobes, the CONVERT ramp count and a frame-done pulse.
// Optional macro PIXEL_STATE_FRAME_CNT_EN adds a 16-bit frame_count output.
module pixel_state #(
  parameter int unsigned C_IDLE    = 2,
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5,
  parameter int unsigned RAMP_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              erase,
  output logic              read,
  output logic              expose,
  output logic              convert,
  output logic [RAMP_W-1:0] ramp_count,
  output logic              frame_done
`ifdef PIXEL_STATE_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  // Zero durations have no meaningful encoding; stop at elaboration.
  if (C_IDLE == 0 || C_ERASE == 0 || C_EXPOSE == 0 || C_CONVERT == 0 || C_READ == 0) begin : g_param_chk
    $fatal(1, "pixel_state: state duration parameters must be >= 1");
  end

  localparam logic [CNT_W-1:0] L_IDLE    = CNT_W'(C_IDLE - 1);
  localparam logic [CNT_W-1:0] L_ERASE   = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0] L_EXPOSE  = CNT_W'(C_EXPOSE - 1);
  localparam logic [CNT_W-1:0] L_CONVERT = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0] L_READ    = CNT_W'(C_READ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // Next-state decode: leave a state on its final counted cycle.
  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    unique case (state)
      S_IDLE: begin
        last = (cnt == L_IDLE);
        if (last) state_nxt = S_ERASE;
      end
      S_ERASE: begin
        last = (cnt == L_ERASE);
        if (last) state_nxt = S_EXPOSE;
      end
      S_EXPOSE: begin
        last = (cnt == L_EXPOSE);
        if (last) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        last = (cnt == L_CONVERT);
        if (last) state_nxt = S_READ;
      end
      S_READ: begin
        last = (cnt == L_READ);
        if (last) state_nxt = S_IDLE;
      end
      default: begin
        last      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, duration counter and registered outputs. Strobes are loaded from
  // the next state so they coincide with the state register, not lag it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= 1'b0;
      ramp_count <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= last ? '0 : cnt + CNT_W'(1);
      erase      <= (state_nxt == S_ERASE);
      expose     <= (state_nxt == S_EXPOSE);
      convert    <= (state_nxt == S_CONVERT);
      read       <= (state_nxt == S_READ);
      frame_done <= (state == S_READ) && last;
      if (state_nxt != S_CONVERT || state != S_CONVERT) begin
        ramp_count <= '0;
      end else if (ramp_count != '1) begin
        ramp_count <= ramp_count + RAMP_W'(1);
      end
    end
  end

`ifdef PIXEL_STATE_FRAME_CNT_EN
  // Completed-frame counter, stepping with the READ->IDLE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (state == S_READ && last) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_state.sv
// tb_pixel_state: checks three pixel_state builds (defaults, long CONVERT,
// minimal durations) against a frame-position model driven by random resets.
module tb_pixel_state;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       a_erase, a_read, a_expose, a_convert, a_fd;
  logic [7:0] a_ramp;
  logic       b_erase, b_read, b_expose, b_convert, b_fd;
  logic [7:0] b_ramp;
  logic       c_erase, c_read, c_expose, c_convert, c_fd;
  logic [7:0] c_ramp;
  logic [15:0] a_fc, b_fc, c_fc;

  int checks = 0;
  int failures = 0;
  int unsigned t = 0;

  always #5 clk = ~clk;

  pixel_state u_a (
    .clk(clk), .reset(reset), .erase(a_erase), .read(a_read), .expose(a_expose),
    .convert(a_convert), .ramp_count(a_ramp), .frame_done(a_fd)
`ifdef PIXEL_STATE_FRAME_CNT_EN
    , .frame_count(a_fc)
`endif
  );

  pixel_state #(.C_CONVERT(300)) u_b (
    .clk(clk), .reset(reset), .erase(b_erase), .read(b_read), .expose(b_expose),
    .convert(b_convert), .ramp_count(b_ramp), .frame_done(b_fd)
`ifdef PIXEL_STATE_FRAME_CNT_EN
    , .frame_count(b_fc)
`endif
  );

  pixel_state #(.C_IDLE(1), .C_ERASE(1), .C_EXPOSE(3), .C_CONVERT(2), .C_READ(1)) u_c (
    .clk(clk), .reset(reset), .erase(c_erase), .read(c_read), .expose(c_expose),
    .convert(c_convert), .ramp_count(c_ramp), .frame_done(c_fd)
`ifdef PIXEL_STATE_FRAME_CNT_EN
    , .frame_count(c_fc)
`endif
  );

`ifndef PIXEL_STATE_FRAME_CNT_EN
  assign a_fc = '0;
  assign b_fc = '0;
  assign c_fc = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected outputs from the position within the frame since reset release.
  // Strobe vector order: {erase, expose, convert, read}.
  function automatic void model(input int unsigned tt, input int unsigned di, input int unsigned de,
                                input int unsigned dx, input int unsigned dc, input int unsigned dr,
                                output logic [3:0] st, output logic [31:0] ramp,
                                output logic fd, output logic [31:0] frames);
    int unsigned period = di + de + dx + dc + dr;
    int unsigned p = tt % period;
    int unsigned q;
    frames = 32'((tt / period) % 65536);
    fd     = (p == 0) && (tt != 0);
    ramp   = 0;
    if (p < di) st = 4'b0000;
    else if (p < di + de) st = 4'b1000;
    else if (p < di + de + dx) st = 4'b0100;
    else if (p < di + de + dx + dc) begin
      st = 4'b0010;
      q = p - (di + de + dx);
      ramp = (q > 255) ? 255 : q;
    end else st = 4'b0001;
  endfunction

  task automatic check_dut(input string n, input logic [3:0] st, input logic [7:0] rc,
                           input logic fd, input logic [15:0] fc,
                           input int unsigned di, input int unsigned de, input int unsigned dx,
                           input int unsigned dc, input int unsigned dr);
    logic [3:0]  e_st;
    logic [31:0] e_ramp, e_frames;
    logic        e_fd;
    model(t, di, de, dx, dc, dr, e_st, e_ramp, e_fd, e_frames);
    chk({n, ".strobes"}, 32'(st), 32'(e_st));
    chk({n, ".onehot0"}, 32'($onehot0(st)), 32'd1);
    chk({n, ".ramp_count"}, 32'(rc), e_ramp);
    chk({n, ".frame_done"}, 32'(fd), 32'(e_fd));
`ifdef PIXEL_STATE_FRAME_CNT_EN
    chk({n, ".frame_count"}, 32'(fc), e_frames);
`else
    if (fc !== 16'd0) chk({n, ".frame_count_absent"}, 32'(fc), 32'd0);
`endif
  endtask

  // One clock: apply reset level, advance the model, sample 1 time unit later.
  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    if (r) t = 0;
    else t++;
    #1;
    check_dut("a", {a_erase, a_expose, a_convert, a_read}, a_ramp, a_fd, a_fc, 2, 5, 255, 255, 5);
    check_dut("b", {b_erase, b_expose, b_convert, b_read}, b_ramp, b_fd, b_fc, 2, 5, 255, 300, 5);
    check_dut("c", {c_erase, c_expose, c_convert, c_read}, c_ramp, c_fd, c_fc, 1, 1, 3, 2, 1);
  endtask

  initial begin
    bit found;

    // Power-up reset, then several full frames.
    repeat (3) step(1'b1);
    repeat (1200) step(1'b0);

    // Reset held 3 cycles part-way through EXPOSE.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0);
      if (a_expose === 1'b1 && t % 522 > 7 + $urandom_range(0, 200)) found = 1;
    end
    chk("wait_expose", 32'(found), 32'd1);
    repeat (3) step(1'b1);
    repeat (600) step(1'b0);

    // Reset landing on the final READ cycle of the default build.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0);
      if (t % 522 == 521) found = 1;
    end
    chk("wait_last_read", 32'(found), 32'd1);
    step(1'b1);
    repeat (1100) step(1'b0);

    // Sporadic random resets of random length.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat ($urandom_range(1, 4)) step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
